// File: rtl/branch_ctrl_if.sv
// Branch-controller signal bundle: ID operands, EX/MEM destination info,
// pipeline control outputs and branch statistics.
interface branch_ctrl_if;
    logic        hold;
    logic        clr_stats;
    logic [2:0]  id_branch_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        mem_mem_read;
    logic [4:0]  mem_rd;
    logic        branch_hazard;
    logic        stall_if_id;
    logic        flush_if_id;
    logic        pc_sel;
    logic [15:0] branch_count;
    logic [15:0] taken_count;
    logic [15:0] stall_count;

    modport master (
        output hold, clr_stats, id_branch_op, id_rs, id_rt,
        output ex_reg_write, ex_mem_read, ex_rd,
        output mem_mem_read, mem_rd, branch_hazard,
        input  stall_if_id, flush_if_id, pc_sel,
        input  branch_count, taken_count, stall_count
    );

    modport slave (
        input  hold, clr_stats, id_branch_op, id_rs, id_rt,
        input  ex_reg_write, ex_mem_read, ex_rd,
        input  mem_mem_read, mem_rd, branch_hazard,
        output stall_if_id, flush_if_id, pc_sel,
        output branch_count, taken_count, stall_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: stalls until forwarded operands are ready,
// then redirects the PC / flushes IF/ID and keeps saturating statistics.
module branch_ctrl (
    input logic          clk,
    input logic          reset,
    branch_ctrl_if.slave bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic [1:0] need;
    logic       is_branch;
    logic       rt_used;
    logic       ex_hit;
    logic       mem_hit;
    logic       stall;
    logic       resolve;
    logic       run;

    logic [15:0] branch_q, taken_q, stall_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign is_branch = bus.id_branch_op inside {3'h1, 3'h4, 3'h5, 3'h6, 3'h7};
    assign rt_used   = (bus.id_branch_op == 3'h4) || (bus.id_branch_op == 3'h5);

    // r0 is hard-wired zero, so it never carries a dependency
    assign ex_hit  = (bus.ex_rd != 5'd0) &&
                     ((bus.ex_rd == bus.id_rs) || (rt_used && bus.ex_rd == bus.id_rt));
    assign mem_hit = (bus.mem_rd != 5'd0) &&
                     ((bus.mem_rd == bus.id_rs) || (rt_used && bus.mem_rd == bus.id_rt));

    // Worst-case producer distance wins; the conditions never add up
    always_comb begin
        need = 2'd0;
        if (bus.ex_mem_read && ex_hit)
            need = 2'd2;
        else if ((bus.ex_reg_write && ex_hit) || (bus.mem_mem_read && mem_hit))
            need = 2'd1;
    end

    // Outputs are silenced during reset and while the pipeline is frozen
    assign run = !reset && !bus.hold;

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        resolve   = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_branch) begin
                    if (need == 2'd0) begin
                        resolve = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        cnt_nxt   = need - 2'd1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt != 2'd0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 2'd1;
                end else begin
                    resolve   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.stall_if_id = run && stall;
    assign bus.pc_sel      = run && resolve && bus.branch_hazard;
    assign bus.flush_if_id = run && resolve && bus.branch_hazard;

    // State and countdown register, frozen while hold is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else if (!bus.hold) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Saturating statistics; clear beats increment but not hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_q <= 16'd0;
            taken_q  <= 16'd0;
            stall_q  <= 16'd0;
        end else if (!bus.hold) begin
            if (bus.clr_stats) begin
                branch_q <= 16'd0;
                taken_q  <= 16'd0;
                stall_q  <= 16'd0;
            end else begin
                if (resolve)
                    branch_q <= sat_inc(branch_q);
                if (resolve && bus.branch_hazard)
                    taken_q <= sat_inc(taken_q);
                if (stall)
                    stall_q <= sat_inc(stall_q);
            end
        end
    end

    assign bus.branch_count = branch_q;
    assign bus.taken_count  = taken_q;
    assign bus.stall_count  = stall_q;

endmodule
